// File: rtl/gte_cop2_bridge_pkg.sv
// Shared GTE definitions: register-select encoding, COP2 op codes and bridge FSM states.
package gte_cop2_bridge_pkg;

    localparam int GTE_DATA_W = 32;
    localparam int CMD_W      = 25;
    localparam int STALL_W    = 16;

    // E_REG: bit 5 selects the control bank, bits 4:0 are the register index.
    typedef logic [5:0] E_REG;

    typedef enum logic [2:0] {
        OP_MTC2 = 3'd0,
        OP_CTC2 = 3'd1,
        OP_MFC2 = 3'd2,
        OP_CFC2 = 3'd3,
        OP_CMD  = 3'd4
    } cop2_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_ACK  = 2'd2
    } bridge_state_e;

    function automatic E_REG make_ereg(input logic [2:0] op, input logic [4:0] idx);
        logic ctrl;
        ctrl = (op == OP_CTC2) || (op == OP_CFC2);
        return {ctrl, idx};
    endfunction

endpackage

// File: rtl/gte_cop2_bridge_if.sv
// CPU-side COP2 request/acknowledge bundle between the execute stage and the bridge.
interface gte_cop2_bridge_if;
    import gte_cop2_bridge_pkg::*;

    logic                  i_cpuReq;
    logic [2:0]            i_cpuOp;
    logic [4:0]            i_cpuRegIdx;
    logic [GTE_DATA_W-1:0] i_cpuData;
    logic [CMD_W-1:0]      i_cpuCmd;
    logic                  o_cpuAck;
    logic [GTE_DATA_W-1:0] o_cpuData;

    modport master (
        output i_cpuReq, i_cpuOp, i_cpuRegIdx, i_cpuData, i_cpuCmd,
        input  o_cpuAck, o_cpuData
    );

    modport slave (
        input  i_cpuReq, i_cpuOp, i_cpuRegIdx, i_cpuData, i_cpuCmd,
        output o_cpuAck, o_cpuData
    );

endinterface

// File: rtl/gte_cop2_bridge_cmd_slot.sv
// One-entry posted command buffer: load when empty, clear on issue.
module gte_cmd_slot
    import gte_cop2_bridge_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CMD_W-1:0] i_cmd,
    input  logic             i_issue,
    output logic             o_full,
    output logic [CMD_W-1:0] o_cmd
);

    logic             full_q, full_d;
    logic [CMD_W-1:0] cmd_q;

    always_comb begin
        full_d = full_q;
        if (i_load) begin
            full_d = 1'b1;
        end else if (i_issue) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // Payload needs no reset; the full flag qualifies it.
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            cmd_q <= i_cmd;
        end
    end

    assign o_full = full_q;
    assign o_cmd  = cmd_q;

endmodule

// File: rtl/gte_cop2_bridge.sv
// COP2 initiator: accepts CPU register/command requests, interlocks against a busy GTE, drives GTE ports.
module gte_cop2_bridge
    import gte_cop2_bridge_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    gte_cop2_bridge_if.slave      cpu,
    output E_REG                  o_regID,
    output logic                  o_WritReg,
    output logic [GTE_DATA_W-1:0] o_dataOut,
    input  logic [GTE_DATA_W-1:0] i_dataIn,
    output logic [CMD_W-1:0]      o_Instruction,
    output logic                  o_run,
    input  logic                  i_executing,
    output logic [STALL_W-1:0]    o_stallCycles
);

    bridge_state_e         state_q;
    logic                  ack_q;
    logic [GTE_DATA_W-1:0] cpu_data_q;
    E_REG                  reg_id_q;
    logic                  wr_q;
    logic [GTE_DATA_W-1:0] data_out_q;
    logic [CMD_W-1:0]      instr_q;
    logic                  run_q;
    logic [STALL_W-1:0]    stall_q;

    logic             slot_full;
    logic [CMD_W-1:0] slot_cmd;
    logic             gte_busy, is_cmd, can_take, accept, slot_issue, slot_load, stall;

    // The o_run cycle counts as busy: the GTE raises i_executing one cycle later.
    assign gte_busy   = i_executing | run_q;
    assign is_cmd     = (cpu.i_cpuOp == OP_CMD);
    // ack_q keeps a still-held request from being taken twice in its ack cycle.
    assign can_take   = cpu.i_cpuReq && (state_q == ST_IDLE) && !slot_full && !ack_q;
    assign accept     = can_take && (is_cmd || !gte_busy);
    assign slot_issue = slot_full && !gte_busy;
    assign slot_load  = accept && is_cmd;
    assign stall      = cpu.i_cpuReq && !accept && (state_q == ST_IDLE) && !ack_q;

    gte_cmd_slot u_slot (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (slot_load),
        .i_cmd   (cpu.i_cpuCmd),
        .i_issue (slot_issue),
        .o_full  (slot_full),
        .o_cmd   (slot_cmd)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            cpu_data_q <= '0;
            reg_id_q   <= '0;
            wr_q       <= 1'b0;
            data_out_q <= '0;
            instr_q    <= '0;
            run_q      <= 1'b0;
            stall_q    <= '0;
        end else begin
            ack_q   <= 1'b0;
            wr_q    <= 1'b0;
            run_q   <= slot_issue;
            instr_q <= slot_issue ? slot_cmd : '0;
            if (stall && (stall_q != '1)) begin
                stall_q <= stall_q + 16'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (cpu.i_cpuOp)
                            OP_MTC2, OP_CTC2: begin
                                reg_id_q   <= make_ereg(cpu.i_cpuOp, cpu.i_cpuRegIdx);
                                data_out_q <= cpu.i_cpuData;
                                wr_q       <= 1'b1;
                                ack_q      <= 1'b1;
                                cpu_data_q <= '0;
                            end
                            OP_MFC2, OP_CFC2: begin
                                reg_id_q <= make_ereg(cpu.i_cpuOp, cpu.i_cpuRegIdx);
                                state_q  <= ST_READ;
                            end
                            default: begin
                                ack_q      <= 1'b1;
                                cpu_data_q <= '0;
                            end
                        endcase
                    end
                end
                ST_READ: begin
                    cpu_data_q <= i_dataIn;
                    ack_q      <= 1'b1;
                    state_q    <= ST_ACK;
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu.o_cpuAck  = ack_q;
    assign cpu.o_cpuData = cpu_data_q;
    assign o_regID       = reg_id_q;
    assign o_WritReg     = wr_q;
    assign o_dataOut     = data_out_q;
    assign o_Instruction = instr_q;
    assign o_run         = run_q;
    assign o_stallCycles = stall_q;

endmodule

// File: tb/tb_gte_cop2_bridge.sv
// Directed bench for gte_cop2_bridge with a small GTE model (busy for 8 cycles after each o_run).
module tb_gte_cop2_bridge;
    import gte_cop2_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    E_REG        regID;
    logic        writReg;
    logic [31:0] dataOut;
    logic [31:0] dataIn;
    logic [24:0] instruction;
    logic        run;
    logic        executing;
    logic [15:0] stallCycles;

    logic        exec_force;
    int          exec_cnt = 0;

    int          n_checks = 0;
    int          n_errors = 0;

    int          cyc = 0;
    int          run_cnt = 0;
    int          wr_cnt = 0;
    int          ack_cnt = 0;
    int          consec = 0;
    logic        prev_run = 1'b0;
    logic [24:0] run_instr [0:15];
    int          run_cyc   [0:15];

    gte_cop2_bridge_if cpu_if ();

    gte_cop2_bridge dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .cpu           (cpu_if),
        .o_regID       (regID),
        .o_WritReg     (writReg),
        .o_dataOut     (dataOut),
        .i_dataIn      (dataIn),
        .o_Instruction (instruction),
        .o_run         (run),
        .i_executing   (executing),
        .o_stallCycles (stallCycles)
    );

    always #5 clk = ~clk;

    // GTE model: register file read is combinational, busy 8 cycles after a start pulse.
    assign dataIn    = (regID == 6'h3F) ? 32'hCAFE_BABE : (32'hA500_0000 | {26'd0, regID});
    assign executing = exec_force | (exec_cnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (run) exec_cnt <= 8;
        else if (exec_cnt != 0) exec_cnt <= exec_cnt - 1;
    end

    always @(negedge clk) begin
        if (run) begin
            run_instr[run_cnt] <= instruction;
            run_cyc[run_cnt]   <= cyc;
            run_cnt            <= run_cnt + 1;
            if (prev_run) consec <= consec + 1;
        end
        prev_run <= run;
        if (writReg) wr_cnt <= wr_cnt + 1;
        if (cpu_if.o_cpuAck) ack_cnt <= ack_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"},   {31'd0, cpu_if.o_cpuAck}, 32'd0);
        chk({tag, "_cdata"}, cpu_if.o_cpuData, 32'd0);
        chk({tag, "_regid"}, {26'd0, regID}, 32'd0);
        chk({tag, "_wr"},    {31'd0, writReg}, 32'd0);
        chk({tag, "_dout"},  dataOut, 32'd0);
        chk({tag, "_instr"}, {7'd0, instruction}, 32'd0);
        chk({tag, "_run"},   {31'd0, run}, 32'd0);
        chk({tag, "_stall"}, {16'd0, stallCycles}, 32'd0);
    endtask

    // Presents one request, holds it until ack (bounded), returns read data and cycles to ack.
    task automatic cpu_op(input string tag, input logic [2:0] op, input logic [4:0] idx,
                          input logic [31:0] wdata, input logic [24:0] cmd,
                          output logic [31:0] rdata, output int lat);
        cpu_if.i_cpuOp     = op;
        cpu_if.i_cpuRegIdx = idx;
        cpu_if.i_cpuData   = wdata;
        cpu_if.i_cpuCmd    = cmd;
        cpu_if.i_cpuReq    = 1'b1;
        lat   = 0;
        rdata = '0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (cpu_if.o_cpuAck) break;
        end
        if (!cpu_if.o_cpuAck) chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
        rdata = cpu_if.o_cpuData;
        cpu_if.i_cpuReq = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat, lat2, s0, r0, w0, a0, ack_c, ack2_c;

        rst                = 1'b1;
        exec_force         = 1'b0;
        cpu_if.i_cpuReq    = 1'b0;
        cpu_if.i_cpuOp     = '0;
        cpu_if.i_cpuRegIdx = '0;
        cpu_if.i_cpuData   = '0;
        cpu_if.i_cpuCmd    = '0;
        idle(3);
        chk_zero("reset");
        rst = 1'b0;
        idle(2);

        // MTC2 idx 5
        cpu_op("mtc2", 3'd0, 5'd5, 32'h1234_5678, 25'd0, rd, lat);
        chk("mtc2_lat",   lat, 32'd1);
        chk("mtc2_wr",    {31'd0, writReg}, 32'd1);
        chk("mtc2_regid", {26'd0, regID}, 32'h05);
        chk("mtc2_dout",  dataOut, 32'h1234_5678);
        idle(1);
        chk("mtc2_wr_pulse",  {31'd0, writReg}, 32'd0);
        chk("mtc2_ack_pulse", {31'd0, cpu_if.o_cpuAck}, 32'd0);

        // CFC2 idx 31
        cpu_op("cfc2", 3'd3, 5'd31, 32'd0, 25'd0, rd, lat);
        chk("cfc2_lat",   lat, 32'd2);
        chk("cfc2_data",  rd, 32'hCAFE_BABE);
        chk("cfc2_regid", {26'd0, regID}, 32'h3F);
        chk("cfc2_wr",    {31'd0, writReg}, 32'd0);

        // CMD then MFC2 while GTE executes the command
        idle(2);
        s0 = int'(stallCycles);
        r0 = run_cnt;
        cpu_op("cmd", 3'd4, 5'd0, 32'd0, 25'h0000012, rd, lat);
        ack_c = cyc;
        chk("cmd_lat", lat, 32'd1);
        cpu_op("mfc2", 3'd2, 5'd3, 32'd0, 25'd0, rd, lat2);
        chk("mfc2_lat",    lat2, 32'd12);
        chk("mfc2_data",   rd, 32'hA500_0003);
        chk("mfc2_regid",  {26'd0, regID}, 32'h03);
        chk("mfc2_stall",  {16'd0, stallCycles}, s0 + 9);
        chk("cmd_runs",    run_cnt - r0, 32'd1);
        chk("cmd_instr",   {7'd0, run_instr[r0]}, 32'h12);
        chk("cmd_run_cyc", run_cyc[r0] - ack_c, 32'd1);

        // Back-to-back CMDs while the GTE is busy
        idle(2);
        r0 = run_cnt;
        exec_force = 1'b1;
        cpu_op("b2b_cmd1", 3'd4, 5'd0, 32'd0, 25'h0000111, rd, lat);
        chk("b2b_cmd1_lat", lat, 32'd1);
        fork
            begin
                cpu_op("b2b_cmd2", 3'd4, 5'd0, 32'd0, 25'h0000222, rd, lat2);
                ack2_c = cyc;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                exec_force = 1'b0;
            end
        join
        idle(14);
        chk("b2b_runs",     run_cnt - r0, 32'd2);
        chk("b2b_instr1",   {7'd0, run_instr[r0]}, 32'h111);
        chk("b2b_instr2",   {7'd0, run_instr[r0 + 1]}, 32'h222);
        chk("b2b_ack2_cyc", ack2_c - run_cyc[r0], 32'd1);
        chk("b2b_run_gap",  run_cyc[r0 + 1] - run_cyc[r0], 32'd10);
        chk("b2b_consec",   consec, 32'd0);
        idle(12);

        // Invalid op 7
        w0 = wr_cnt;
        r0 = run_cnt;
        cpu_op("inv", 3'd7, 5'd9, 32'hFFFF_FFFF, 25'h1FFFFFF, rd, lat);
        chk("inv_lat",  lat, 32'd1);
        chk("inv_data", rd, 32'd0);
        chk("inv_wr",   {31'd0, writReg}, 32'd0);
        idle(3);
        chk("inv_wr_cnt",  wr_cnt - w0, 32'd0);
        chk("inv_run_cnt", run_cnt - r0, 32'd0);

        // Reset while in READ
        cpu_if.i_cpuOp     = 3'd2;
        cpu_if.i_cpuRegIdx = 5'd3;
        cpu_if.i_cpuReq    = 1'b1;
        idle(1);
        chk("rst_rd_regid", {26'd0, regID}, 32'h03);
        rst             = 1'b1;
        cpu_if.i_cpuReq = 1'b0;
        idle(1);
        chk_zero("rst_rd");
        rst = 1'b0;
        a0  = ack_cnt;
        idle(3);
        chk("rst_rd_no_ack", ack_cnt - a0, 32'd0);

        // Reset with a command held in the slot
        exec_force = 1'b1;
        cpu_op("rst_cmd", 3'd4, 5'd0, 32'd0, 25'h1ABCDEF, rd, lat);
        chk("rst_cmd_lat", lat, 32'd1);
        idle(1);
        r0  = run_cnt;
        rst = 1'b1;
        idle(1);
        chk_zero("rst_slot");
        rst        = 1'b0;
        exec_force = 1'b0;
        idle(12);
        chk("rst_slot_no_run", run_cnt - r0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
